// File: rtl/lfsr_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | lfsr_pkg : mode encodings and default tap/seed constants for lfsr_engine |
// | Rev 1.0                                                                |
// +-----------------------------------------------------------------------+
package lfsr_pkg;

  localparam logic [1:0] MODE_HOLD = 2'd0;
  localparam logic [1:0] MODE_RUN  = 2'd1;
  localparam logic [1:0] MODE_STEP = 2'd2;

  // Masks list the low-order terms of a primitive polynomial (bit i <-> x^i).
  localparam logic [7:0]  TAPS_8  = 8'h1D;
  localparam logic [7:0]  SEED_8  = 8'h01;
  localparam logic [15:0] TAPS_16 = 16'hA011;
  localparam logic [15:0] SEED_16 = 16'h0001;
  localparam logic [31:0] TAPS_32 = 32'h0040_0007;
  localparam logic [31:0] SEED_32 = 32'h0000_0001;

endpackage
`default_nettype wire

// File: rtl/tick_divider.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tick_divider : enable-gated prescaler, one tick every CLK_DIV clocks   |
// | Rev 1.0                                                                |
// +-----------------------------------------------------------------------+
module tick_divider #(
  parameter int CLK_DIV = 5000000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_en,
  output logic o_tick
);

  localparam int              c_CW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [c_CW-1:0] c_LAST = c_CW'(CLK_DIV - 1);

  logic [c_CW-1:0] r_cnt;

  // Dropping the enable restarts the count, so re-entry waits a full period.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (!i_en || (r_cnt == c_LAST)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_tick = i_en && (r_cnt == c_LAST);

endmodule
`default_nettype wire

// File: rtl/lfsr_engine.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | lfsr_engine : reversible Fibonacci LFSR with run/step/load control     |
// | Rev 1.0                                                                |
// +-----------------------------------------------------------------------+
module lfsr_engine
  import lfsr_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] TAPS    = 8'h1D,
  parameter logic [WIDTH-1:0] SEED    = 8'h01,
  parameter int               CLK_DIV = 5000000
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [1:0]       i_mode,
  input  logic             i_dir,
  input  logic             i_step,
  input  logic             i_load_valid,
  input  logic [WIDTH-1:0] i_load_data,
  output logic             o_load_ready,
  output logic [WIDTH-1:0] o_num,
  output logic             o_adv,
  output logic             o_wrap,
  output logic             o_lockup,
  output logic [31:0]      o_count
);

  function automatic logic [WIDTH-1:0] step_fwd(input logic [WIDTH-1:0] s);
    return {^(s & TAPS), s[WIDTH-1:1]};
  endfunction

  // TAPS[0]=1 makes the forward map invertible; this recovers the dropped bit.
  function automatic logic [WIDTH-1:0] step_bwd(input logic [WIDTH-1:0] s);
    return {s[WIDTH-2:0], s[WIDTH-1] ^ (^(s[WIDTH-2:0] & TAPS[WIDTH-1:1]))};
  endfunction

  logic [WIDTH-1:0] r_num;
  logic [WIDTH-1:0] r_anchor;
  logic [31:0]      r_count;
  logic             r_adv;
  logic             r_wrap;
  logic             r_lockup;
  logic             r_load_ready;
  logic             r_step_q;

  logic             w_tick;
  logic             w_accept;
  logic             w_advance;
  logic [WIDTH-1:0] w_next;
  logic             w_hit;

  tick_divider #(
    .CLK_DIV (CLK_DIV)
  ) u_tick_divider (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_en    (i_mode == MODE_RUN),
    .o_tick  (w_tick)
  );

  always_comb begin
    w_accept  = i_load_valid && r_load_ready;
    w_advance = ((i_mode == MODE_RUN) && w_tick) ||
                ((i_mode == MODE_STEP) && i_step && !r_step_q);
    w_next    = i_dir ? step_bwd(r_num) : step_fwd(r_num);
    w_hit     = (w_next == r_anchor);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_num        <= SEED;
      r_anchor     <= SEED;
      r_count      <= '0;
      r_adv        <= 1'b0;
      r_wrap       <= 1'b0;
      r_lockup     <= 1'b0;
      r_load_ready <= 1'b1;
      r_step_q     <= 1'b0;
    end else begin
      r_step_q     <= i_step;
      r_load_ready <= !w_accept;
      r_adv        <= 1'b0;
      r_wrap       <= 1'b0;
      r_lockup     <= 1'b0;
      if (w_accept) begin
        // An all-zero load would lock the register up, so it is reseeded.
        if (i_load_data == '0) begin
          r_num    <= SEED;
          r_anchor <= SEED;
          r_lockup <= 1'b1;
        end else begin
          r_num    <= i_load_data;
          r_anchor <= i_load_data;
        end
        r_count <= '0;
      end else if (w_advance) begin
        r_num <= w_next;
        r_adv <= 1'b1;
        if (w_hit) begin
          r_wrap  <= 1'b1;
          r_count <= '0;
        end else if (i_dir) begin
          r_count <= (r_count == '0) ? '0 : r_count - 32'd1;
        end else begin
          r_count <= (r_count == 32'hFFFF_FFFF) ? r_count : r_count + 32'd1;
        end
      end
    end
  end

  assign o_num        = r_num;
  assign o_count      = r_count;
  assign o_adv        = r_adv;
  assign o_wrap       = r_wrap;
  assign o_lockup     = r_lockup;
  assign o_load_ready = r_load_ready;

endmodule
`default_nettype wire

// File: doc/lfsr_engine.md
LFSR_ENGINE -- requirements
Module: lfsr_engine

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the shift-register width (3..32).
REQ-002 The block SHALL have parameter TAPS, default 8'h1D, giving the WIDTH-bit feedback mask; bit 0 SHALL be 1.
REQ-003 The block SHALL have parameter SEED, default 8'h01, giving the non-zero reset and reseed value.
REQ-004 The block SHALL have parameter CLK_DIV, default 5000000, giving the clocks per free-run advance (>=1).
REQ-005 The block SHALL have port i_clk, input, 1 bit: the single clock, rising edge.
REQ-006 The block SHALL have port i_rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 The block SHALL have port i_mode, input, 2 bits: 0 hold, 1 free-run, 2 single-step, 3 hold.
REQ-008 The block SHALL have port i_dir, input, 1 bit: 0 forward, 1 backward.
REQ-009 The block SHALL have port i_step, input, 1 bit: single-step request, level; only the rising edge counts.
REQ-010 The block SHALL have port i_load_valid, input, 1 bit, and port i_load_data, input, WIDTH bits: the load request and its value.
REQ-011 The block SHALL have port o_load_ready, output, 1 bit: load accepted this cycle when valid and ready are both 1.
REQ-012 The block SHALL have port o_num, output, WIDTH bits: the current state.
REQ-013 The block SHALL have port o_adv, output, 1 bit: one-cycle pulse on every advance.
REQ-014 The block SHALL have port o_wrap, output, 1 bit: one-cycle pulse when an advance returns the state to the anchor value.
REQ-015 The block SHALL have port o_lockup, output, 1 bit: one-cycle pulse when an all-zero state is reseeded.
REQ-016 The block SHALL have port o_count, output, 32 bits: advances since the last anchor.

Function
REQ-017 Forward advance SHALL compute fb = XOR of (o_num AND TAPS) and set o_num <= {fb, o_num[WIDTH-1:1]}.
REQ-018 Backward advance SHALL exactly invert forward: o_num <= {o_num[WIDTH-2:0], b0}, b0 = o_num[WIDTH-1] XOR XOR(o_num[WIDTH-2:0] AND TAPS[WIDTH-1:1]).
REQ-019 The prescaler SHALL count 0..CLK_DIV-1 only in mode 1; a tick SHALL occur when it reaches CLK_DIV-1, and it SHALL then wrap to 0.
REQ-020 Leaving mode 1 SHALL clear the prescaler, so the first tick after re-entry comes CLK_DIV clocks later.
REQ-021 In mode 2, each 0->1 edge of i_step (registered, 1-clock detect latency) SHALL cause exactly one advance; a held level SHALL cause no further advances.
REQ-022 In modes 0 and 3 the state, prescaler and o_count SHALL hold.
REQ-023 o_load_ready SHALL be 1 except in the cycle after an accepted load, when it SHALL be 0 (one-cycle turnaround).
REQ-024 An accepted load SHALL set o_num to i_load_data, make it the anchor, and clear o_count; it SHALL take priority over a same-cycle advance, which is dropped.
REQ-025 A load of zero SHALL instead load SEED, make SEED the anchor, and pulse o_lockup.
REQ-026 o_adv SHALL pulse, and o_count SHALL increment, in the cycle o_num updates; o_count SHALL saturate at 32'hFFFFFFFF.
REQ-027 On an advance whose new state equals the anchor, o_wrap SHALL pulse and o_count SHALL reload to 0.
REQ-028 Backward advances SHALL decrement o_count; a decrement from 0 SHALL wrap to 0 with an o_wrap pulse only if the new state equals the anchor, and otherwise saturate at 0.
REQ-029 A dir change SHALL take effect on the next advance, with no extra cycle.

Reset
REQ-030 While i_rst_n=0, o_num and the anchor SHALL be SEED; the prescaler, o_count, o_adv, o_wrap and o_lockup SHALL be 0; o_load_ready SHALL be 1; and the step-edge register SHALL be 0.
REQ-031 Reset asserted mid-prescale or mid-handshake SHALL abandon the operation with no pulse on o_adv, o_wrap or o_lockup.

Structure
REQ-032 Package lfsr_pkg SHALL hold the mode encodings (MODE_HOLD, MODE_RUN, MODE_STEP) and the default TAPS/SEED constants for widths 8, 16 and 32.
REQ-033 The prescaler SHALL be the sub-module tick_divider (parameter CLK_DIV; ports i_clk, i_rst_n, i_en; output o_tick).

Verification
REQ-034 WIDTH=8, TAPS=1D, SEED=01, CLK_DIV=4, mode 1: o_num SHALL sequence 01->80->40->20 with o_adv every 4 clocks.
REQ-035 Mode 1 for 255 advances: o_wrap SHALL pulse on advance 255 with o_num=01 (maximal length), and o_count SHALL go 254->0.
REQ-036 Mode 2, dir 0 then dir 1, i_step pulsed 3 times each: o_num SHALL return to its start value, o_count=0, with 6 o_adv pulses.
REQ-037 Load 8'h00: o_num=01 and o_lockup=1 for one cycle; load 8'h5A with a same-cycle tick: o_num=5A, no o_adv, o_load_ready=0 next cycle.
REQ-038 i_rst_n low at prescaler=2 with a step edge pending: o_num=01, all pulses 0; after release, the first tick SHALL come 4 clocks later.
